// File: rtl/fifo_fwft.sv
// Synchronous FIFO with selectable first-word-fall-through or registered read.
// Pointers carry an extra wrap bit so all DEPTH entries are usable; occupancy
// is kept in a registered counter from which every status flag is derived.
module fifo_fwft #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FWFT       = 1,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ovf,
  output logic                  udf
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_C    = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_C    = AE_LEVEL[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0]   wr_ptr_reg;
  logic [ADDR_WIDTH:0]   rd_ptr_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  ovf_reg;
  logic                  udf_reg;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign wr_addr = wr_ptr_reg[ADDR_WIDTH-1:0];
  assign rd_addr = rd_ptr_reg[ADDR_WIDTH-1:0];

  // Status flags come straight from the registered occupancy.
  assign count        = count_reg;
  assign full         = (count_reg == DEPTH_C);
  assign empty        = (count_reg == '0);
  assign almost_full  = (count_reg >= AF_C);
  assign almost_empty = (count_reg <= AE_C);
  assign ovf          = ovf_reg;
  assign udf          = udf_reg;

  // Accept decisions; a flush suppresses both sides, and a pop frees room for a push when full.
  always_comb begin
    rd_acc     = rd && !empty && !clr;
    wr_acc     = wr && (!full || rd_acc) && !clr;
    count_next = count_reg;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Pointer, occupancy and sticky error state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
      udf_reg    <= 1'b0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
      udf_reg    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_acc) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      if (wr && !wr_acc) ovf_reg <= 1'b1;
      if (rd && empty)   udf_reg <= 1'b1;
    end
  end

  // Storage array write port; contents are never cleared.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_addr] <= w_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown directly; forced to zero while nothing is stored.
      always_comb begin
        r_data  = empty ? '0 : mem[rd_addr];
        r_valid = !empty;
      end
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_data_reg;
      logic                  r_valid_reg;

      // Registered read: load the head on a pop, pulse valid for one cycle.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_data_reg  <= '0;
          r_valid_reg <= 1'b0;
        end else begin
          r_valid_reg <= rd_acc;
          if (rd_acc) r_data_reg <= mem[rd_addr];
        end
      end

      assign r_data  = r_data_reg;
      assign r_valid = r_valid_reg;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_fwft.sv
// Directed bench for fifo_fwft: one FWFT instance plus one standard-read instance.
module tb_fifo_fwft;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr, wr, rd;
  logic [7:0] w_data;
  logic [7:0] r_data;
  logic       r_valid, full, empty, almost_full, almost_empty, ovf, udf;
  logic [4:0] count;

  logic       clr0, wr0, rd0;
  logic [7:0] w_data0;
  logic [7:0] r_data0;
  logic       r_valid0, full0, empty0, almost_full0, almost_empty0, ovf0, udf0;
  logic [4:0] count0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_fwft #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .FWFT(1)) dut (
    .clk(clk), .reset(reset), .clr(clr), .wr(wr), .w_data(w_data), .rd(rd),
    .r_data(r_data), .r_valid(r_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .ovf(ovf), .udf(udf)
  );

  fifo_fwft #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .FWFT(0)) dut0 (
    .clk(clk), .reset(reset), .clr(clr0), .wr(wr0), .w_data(w_data0), .rd(rd0),
    .r_data(r_data0), .r_valid(r_valid0), .full(full0), .empty(empty0),
    .almost_full(almost_full0), .almost_empty(almost_empty0), .count(count0),
    .ovf(ovf0), .udf(udf0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_d;
    bit         do_wr, do_rd;
    int         sel;

    reset = 1'b0; clr = 0; wr = 0; rd = 0; w_data = 0;
    clr0 = 0; wr0 = 0; rd0 = 0; w_data0 = 0;
    #3;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_udf", udf, 0);
    chk("rst_rvalid", r_valid, 0);
    chk("rst_rdata", r_data, 0);
    chk("rst_rvalid0", r_valid0, 0);
    chk("rst_rdata0", r_data0, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      wr = 1; w_data = 8'(i);
      tick();
      $display("fill wr %02h count=%0d", i, count);
      chk("fill_count", count, i + 1);
      chk("fill_full", full, (i + 1 == 16));
      chk("fill_af", almost_full, (i + 1 >= 14));
      chk("fill_ae", almost_empty, (i + 1 <= 2));
      chk("fill_head", r_data, 8'h00);
    end
    wr = 0;

    // Drain in order
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", r_data, i);
      chk("drain_valid", r_valid, 1);
      rd = 1;
      tick();
      $display("drain rd %02h count=%0d", i, count);
    end
    rd = 0;
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);

    // Underflow then flush
    rd = 1; tick(); rd = 0;
    $display("underflow count=%0d udf=%0b", count, udf);
    chk("udf_set", udf, 1);
    chk("udf_count", count, 0);
    tick();
    chk("udf_sticky", udf, 1);
    clr = 1; tick(); clr = 0;
    chk("clr_udf", udf, 0);

    // Refill 0x20..0x2F
    for (int i = 0; i < 16; i++) begin
      wr = 1; w_data = 8'(8'h20 + i);
      tick();
    end
    $display("refill count=%0d", count);
    chk("refill_full", full, 1);

    // Simultaneous push/pop while full
    wr = 1; rd = 1; w_data = 8'h30;
    tick();
    wr = 0; rd = 0;
    $display("full wr+rd count=%0d ovf=%0b", count, ovf);
    chk("sim_full_count", count, 16);
    chk("sim_full_ovf", ovf, 0);
    chk("sim_full_head", r_data, 8'h21);

    // Overflow
    wr = 1; w_data = 8'hEE;
    tick();
    wr = 0;
    $display("overflow count=%0d ovf=%0b", count, ovf);
    chk("ovf_count", count, 16);
    chk("ovf_set", ovf, 1);

    // Drain 0x21..0x30, ensuring the dropped word never appears
    for (int i = 0; i < 16; i++) begin
      chk("ovf_drain", r_data, 8'h21 + i);
      rd = 1;
      tick();
    end
    rd = 0;
    $display("ovf drain done empty=%0b", empty);
    chk("ovf_drain_empty", empty, 1);
    chk("ovf_sticky", ovf, 1);
    clr = 1; tick(); clr = 0;
    chk("clr_ovf", ovf, 0);
    chk("clr_udf2", udf, 0);

    // Simultaneous push/pop while empty
    wr = 1; rd = 1; w_data = 8'h5A;
    tick();
    wr = 0; rd = 0;
    $display("empty wr+rd count=%0d udf=%0b r_data=%02h", count, udf, r_data);
    chk("sim_empty_count", count, 1);
    chk("sim_empty_udf", udf, 1);
    chk("sim_empty_data", r_data, 8'h5A);
    chk("sim_empty_empty", empty, 0);
    rd = 1; tick(); rd = 0;
    clr = 1; tick(); clr = 0;

    // FWFT latency
    wr = 1; w_data = 8'hA5;
    tick();
    wr = 0;
    $display("fwft wr a5 r_data=%02h empty=%0b", r_data, empty);
    chk("fwft_data", r_data, 8'hA5);
    chk("fwft_empty", empty, 0);
    chk("fwft_valid", r_valid, 1);
    rd = 1; tick(); rd = 0;
    chk("fwft_pop_empty", empty, 1);

    // Standard read latency
    wr0 = 1; w_data0 = 8'hA5;
    tick();
    wr0 = 0;
    chk("std_valid_idle", r_valid0, 0);
    chk("std_count", count0, 1);
    rd0 = 1;
    tick();
    rd0 = 0;
    $display("std rd r_data0=%02h r_valid0=%0b", r_data0, r_valid0);
    chk("std_data", r_data0, 8'hA5);
    chk("std_valid", r_valid0, 1);
    tick();
    chk("std_valid_pulse", r_valid0, 0);
    chk("std_data_hold", r_data0, 8'hA5);
    clr0 = 1; tick(); clr0 = 0;

    // Random interleave with wrap, occupancy held within 3..10
    clr = 1; tick(); clr = 0;
    q.delete();
    for (int i = 0; i < 5; i++) begin
      wr = 1; w_data = 8'($urandom_range(255));
      q.push_back(w_data);
      tick();
    end
    wr = 0;
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(2));
      do_wr = (q.size() <= 3) || (q.size() < 10 && sel != 1);
      do_rd = (q.size() >= 10) || (q.size() > 3 && sel != 0);
      wr = do_wr; rd = do_rd;
      w_data = 8'($urandom_range(255));
      if (do_rd) begin
        exp_d = q[0];
        chk("wrap_data", r_data, exp_d);
      end
      tick();
      if (do_rd) void'(q.pop_front());
      if (do_wr) q.push_back(w_data);
      $display("wrap %0d wr=%0b rd=%0b count=%0d model=%0d", i, do_wr, do_rd, count, q.size());
      chk("wrap_count", count, q.size());
    end
    wr = 0; rd = 0;

    // Reset mid-stream at count 7
    clr = 1; tick(); clr = 0;
    for (int i = 0; i < 7; i++) begin
      wr = 1; w_data = 8'(8'h60 + i);
      tick();
    end
    wr = 0;
    chk("pre_rst_count", count, 7);
    #1;
    reset = 1'b0;
    #1;
    $display("async reset count=%0d empty=%0b", count, empty);
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_ae", almost_empty, 1);
    chk("arst_rdata", r_data, 0);
    #1;
    reset = 1'b1;
    wr = 1; w_data = 8'h77;
    tick();
    wr = 0;
    $display("post reset wr 77 r_data=%02h count=%0d", r_data, count);
    chk("post_rst_data", r_data, 8'h77);
    chk("post_rst_count", count, 1);
    rd = 1; tick(); rd = 0;
    chk("post_rst_empty", empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_fwft.md
FIFO_FWFT -- requirements
Module: fifo_fwft

Interface
REQ-001 The module SHALL take parameter ADDR_WIDTH, default 4: log2 of depth; DEPTH = 2^ADDR_WIDTH entries.
REQ-002 The module SHALL take parameter DATA_WIDTH, default 8: word width in bits.
REQ-003 The module SHALL take parameter FWFT, default 1: 1 = first-word-fall-through read; 0 = standard read with 1-cycle latency.
REQ-004 The module SHALL take parameter AF_LEVEL, default DEPTH-2: almost_full asserts when count >= AF_LEVEL.
REQ-005 The module SHALL take parameter AE_LEVEL, default 2: almost_empty asserts when count <= AE_LEVEL.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-007 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset; state clears while reset = 0.
REQ-008 The module SHALL have port clr, input, 1 bit: synchronous flush.
REQ-009 The module SHALL have port wr, input, 1 bit: write request.
REQ-010 The module SHALL have port w_data, input, DATA_WIDTH bits: write data.
REQ-011 The module SHALL have port rd, input, 1 bit: read/pop request.
REQ-012 The module SHALL have port r_data, output, DATA_WIDTH bits: read data.
REQ-013 The module SHALL have port r_valid, output, 1 bit: r_data qualifier.
REQ-014 The module SHALL have ports full, empty, almost_full, almost_empty, output, 1 bit each: status flags.
REQ-015 The module SHALL have port count, output, ADDR_WIDTH+1 bits: occupancy, 0..DEPTH.
REQ-016 The module SHALL have ports ovf and udf, output, 1 bit each: sticky overflow and underflow error flags.

Function
REQ-017 Storage SHALL use DEPTH entries, all usable; read and write pointers SHALL be ADDR_WIDTH+1 bits with the MSB as wrap bit.
REQ-018 full SHALL be 1 exactly when count = DEPTH; empty SHALL be 1 exactly when count = 0; all flags SHALL be registered or derived from registered count only.
REQ-019 A write SHALL be accepted when wr = 1 and (full = 0 or an accepted read occurs in the same cycle); w_data SHALL be stored at the write pointer, which then increments modulo 2^(ADDR_WIDTH+1).
REQ-020 A read SHALL be accepted when rd = 1 and empty = 0; the read pointer SHALL then increment.
REQ-021 Write and read accepted in the same cycle SHALL leave count unchanged; a write alone SHALL give count+1; a read alone SHALL give count-1.
REQ-022 wr = 1 while full = 1 with no accepted read SHALL drop the word, leave state unchanged and set ovf.
REQ-023 rd = 1 while empty = 1 SHALL be ignored and SHALL set udf, including when wr = 1 in the same cycle; in that case the write is still accepted.
REQ-024 ovf and udf SHALL stay set until reset or clr.
REQ-025 In FWFT = 1, r_data SHALL present the head word and r_valid SHALL equal ~empty; a word written into an empty FIFO SHALL appear on r_data with empty = 0 one cycle after the write edge; rd acts as acknowledge and the next word SHALL appear in the same cycle the pointer advances (no bubble).
REQ-026 In FWFT = 0, r_data SHALL be a register loaded from the head on an accepted read; r_valid SHALL pulse 1 in the cycle after the accepted read; r_data SHALL hold its value otherwise.
REQ-027 clr = 1 SHALL zero both pointers, count, ovf, udf and r_valid on the next edge; clr SHALL take priority over wr and rd in the same cycle; memory contents need not be cleared.
REQ-028 Pointer wrap SHALL be seamless; ordering SHALL be strict FIFO across any number of wraps.
REQ-029 The block SHALL be synthesisable with no latches.

Reset
REQ-030 While reset = 0: pointers = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, ovf = 0, udf = 0, r_valid = 0, r_data = 0.
REQ-031 Reset assertion mid-operation SHALL discard all contents immediately (asynchronously); after release, the first write SHALL land at address 0.

Verification
REQ-032 Fill/drain: DEPTH=16, FWFT=1, write 0x00..0x0F -> full = 1 after the 16th edge, count = 16, almost_full asserted at count 14; read 16 words -> data 0x00..0x0F in order, then empty = 1.
REQ-033 Overflow/underflow: write a 17th word when full -> count stays 16, ovf = 1, data intact; rd when empty -> udf = 1, count = 0; clr -> both flags 0.
REQ-034 Simultaneous access: at count = 16, wr and rd in the same cycle -> count stays 16, ovf = 0; at count = 0, wr and rd -> count = 1, udf = 1, word visible next cycle.
REQ-035 FWFT latency: write 0xA5 into an empty FIFO -> r_data = 0xA5 and empty = 0 on the following cycle; with FWFT = 0, rd -> r_data = 0xA5 and r_valid = 1 one cycle after rd.
REQ-036 Wrap: 40 interleaved random writes and reads with count kept at 3-10 -> scoreboard match and count consistent with the model every cycle.
REQ-037 Reset mid-stream: assert reset low at count = 7 between clock edges -> flags and count return to reset values without a clock edge; subsequent write/read returns the new data.
